// File: rtl/keypad_scanner_if.sv
// SoC-facing port bundle of the keypad scanner: queue head, status and the pop request.
interface keypad_scanner_if #(
  parameter int FIFO_DEPTH = 4
);
  logic                          key_ack;
  logic [7:0]                    key_data;
  logic                          key_valid;
  logic                          overflow;
  logic [$clog2(FIFO_DEPTH):0]   fifo_count;

  modport master (
    input  key_ack,
    output key_data,
    output key_valid,
    output overflow,
    output fifo_count
  );

  modport slave (
    output key_ack,
    input  key_data,
    input  key_valid,
    input  overflow,
    input  fifo_count
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: row rotation, whole-frame debounce and a small key-code FIFO
// whose head is presented on an 8-bit SoC input port and popped by a rising edge of key_ack.
module keypad_scanner #(
  parameter int SCAN_TICKS      = 120000,
  parameter int DEBOUNCE_FRAMES = 4,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic              clk,
  input  logic              reset,
  output logic [3:0]        row_n,
  input  logic [3:0]        col_n,
  keypad_scanner_if.master  bus
);
  localparam int TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int DW = $clog2(DEBOUNCE_FRAMES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(SCAN_TICKS - 1);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_FRAMES);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CAND = 2'd1,
    ST_HELD = 2'd2
  } state_t;

  function automatic logic [3:0] row_drive(input logic [1:0] r);
    return ~(4'b0001 << r);
  endfunction

  logic [TW-1:0] timer_r;
  logic [1:0]    row_r;
  logic [3:0]    row_n_r;
  logic [3:0]    col_meta_r;
  logic [3:0]    col_sync_r;
  logic          acc_hit_r;
  logic [3:0]    acc_key_r;
  state_t        state_r, state_n;
  logic [3:0]    cand_r, cand_n;
  logic [DW-1:0] cnt_r, cnt_n;
  logic [DW-1:0] rel_r, rel_n;
  logic          ack_q_r;
  logic [3:0]    mem_r [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          overflow_r;

  logic          sample_s, frame_end_s, row_hit_s, frame_hit_s;
  logic [1:0]    row_col_s;
  logic [3:0]    row_code_s, frame_key_s, push_code_s;
  logic          push_s, pop_do_s, push_do_s, full_s, valid_s;

  // Row timer: advance the driven row after the last tick of each row slot
  always_ff @(posedge clk) begin
    if (!reset) begin
      timer_r <= '0;
      row_r   <= 2'd0;
      row_n_r <= 4'b1110;
    end else if (sample_s) begin
      timer_r <= '0;
      row_r   <= row_r + 2'd1;
      row_n_r <= row_drive(row_r + 2'd1);
    end else begin
      timer_r <= timer_r + TW'(1);
    end
  end

  // Two-flop synchronizer for the asynchronous column lines
  always_ff @(posedge clk) begin
    if (!reset) begin
      col_meta_r <= 4'hF;
      col_sync_r <= 4'hF;
    end else begin
      col_meta_r <= col_n;
      col_sync_r <= col_meta_r;
    end
  end

  // Row sample decode; rows are visited in ascending order so the first hit is the lowest code
  always_comb begin
    sample_s    = (timer_r == TIMER_LAST);
    frame_end_s = sample_s && (row_r == 2'd3);
    row_hit_s   = (col_sync_r != 4'hF);
    row_col_s   = 2'd0;
    if (!col_sync_r[0])      row_col_s = 2'd0;
    else if (!col_sync_r[1]) row_col_s = 2'd1;
    else if (!col_sync_r[2]) row_col_s = 2'd2;
    else if (!col_sync_r[3]) row_col_s = 2'd3;
    else                     row_col_s = 2'd0;
    row_code_s  = {row_r, row_col_s};
    frame_hit_s = acc_hit_r | row_hit_s;
    frame_key_s = acc_hit_r ? acc_key_r : row_code_s;
  end

  // Per-frame accumulator of the lowest key seen in rows 0..2
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc_hit_r <= 1'b0;
      acc_key_r <= 4'h0;
    end else if (frame_end_s) begin
      acc_hit_r <= 1'b0;
      acc_key_r <= 4'h0;
    end else if (sample_s && row_hit_s && !acc_hit_r) begin
      acc_hit_r <= 1'b1;
      acc_key_r <= row_code_s;
    end
  end

  // Debounce state register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= ST_IDLE;
      cand_r  <= 4'h0;
      cnt_r   <= '0;
      rel_r   <= '0;
    end else begin
      state_r <= state_n;
      cand_r  <= cand_n;
      cnt_r   <= cnt_n;
      rel_r   <= rel_n;
    end
  end

  // Debounce next-state logic, stepped only at frame end
  always_comb begin
    state_n     = state_r;
    cand_n      = cand_r;
    cnt_n       = cnt_r;
    rel_n       = rel_r;
    push_s      = 1'b0;
    push_code_s = frame_key_s;
    if (frame_end_s) begin
      case (state_r)
        ST_IDLE: begin
          if (frame_hit_s) begin
            cand_n = frame_key_s;
            if (DEBOUNCE_FRAMES == 1) begin
              push_s  = 1'b1;
              state_n = ST_HELD;
              rel_n   = '0;
            end else begin
              cnt_n   = DW'(1);
              state_n = ST_CAND;
            end
          end else begin
            cnt_n = '0;
          end
        end
        ST_CAND: begin
          if (frame_hit_s && (frame_key_s == cand_r)) begin
            if ((cnt_r + DW'(1)) == DEB_LAST) begin
              push_s  = 1'b1;
              state_n = ST_HELD;
              rel_n   = '0;
            end else begin
              cnt_n = cnt_r + DW'(1);
            end
          end else if (frame_hit_s) begin
            cand_n = frame_key_s;
            cnt_n  = DW'(1);
          end else begin
            state_n = ST_IDLE;
            cnt_n   = '0;
          end
        end
        ST_HELD: begin
          if (frame_hit_s) begin
            rel_n = '0;
          end else if ((rel_r + DW'(1)) == DEB_LAST) begin
            state_n = ST_IDLE;
            rel_n   = '0;
          end else begin
            rel_n = rel_r + DW'(1);
          end
        end
        default: begin
          state_n = ST_IDLE;
          cnt_n   = '0;
          rel_n   = '0;
        end
      endcase
    end else begin
      state_n = state_r;
    end
  end

  // Previous key_ack level for rising-edge detection
  always_ff @(posedge clk) begin
    if (!reset) ack_q_r <= 1'b0;
    else        ack_q_r <= bus.key_ack;
  end

  // A full FIFO still accepts a push when the same cycle pops
  always_comb begin
    valid_s   = (count_r != '0);
    full_s    = (count_r == FIFO_FULL);
    pop_do_s  = bus.key_ack && !ack_q_r && valid_s;
    push_do_s = push_s && (!full_s || pop_do_s);
  end

  // Key-code FIFO storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= 4'h0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      overflow_r <= 1'b0;
    end else begin
      if (push_do_s) begin
        mem_r[wr_ptr_r] <= push_code_s;
        wr_ptr_r        <= wr_ptr_r + AW'(1);
      end
      if (pop_do_s) rd_ptr_r <= rd_ptr_r + AW'(1);
      case ({push_do_s, pop_do_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
      if (push_s && full_s && !pop_do_s) overflow_r <= 1'b1;
    end
  end

  assign row_n          = row_n_r;
  assign bus.key_valid  = valid_s;
  assign bus.overflow   = overflow_r;
  assign bus.fifo_count = count_r;
  assign bus.key_data   = {valid_s, overflow_r, 2'b00, valid_s ? mem_r[rd_ptr_r] : 4'h0};
endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: frame-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized key/ack traffic.
module tb_keypad_scanner;
  localparam int ST    = 4;
  localparam int DEB   = 2;
  localparam int DEPTH = 4;
  localparam int FRAME = 4 * ST;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] keys = 16'h0000;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_scanner_if #(.FIFO_DEPTH(DEPTH)) bus();

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_FRAMES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .row_n (row_n),
    .col_n (col_n),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // A pressed key shorts its row line to its column line
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_n[r] == 1'b0 && keys[4*r+c]) col_n[c] = 1'b0;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  int         m_edges = 0;
  logic [3:0] m_q[$];
  bit         m_ovf = 1'b0, m_ack_q = 1'b0, m_pop, m_push, chk_en = 1'b0;
  int         m_state = 0, m_cand = 0, m_cnt = 0, m_rel = 0, fk;
  logic [3:0] e_row;
  logic [7:0] e_data;

  initial forever begin
    @(posedge clk);
    if (!reset) begin
      m_edges = 0; m_q.delete(); m_ovf = 1'b0; m_ack_q = 1'b0;
      m_state = 0; m_cand = 0; m_cnt = 0; m_rel = 0; chk_en = 1'b1;
    end else begin
      m_pop   = bus.key_ack && !m_ack_q;
      m_ack_q = bus.key_ack;
      m_push  = 1'b0;
      m_edges++;
      if (m_edges % FRAME == 0) begin
        fk = -1;
        for (int i = 15; i >= 0; i--) if (keys[i]) fk = i;
        case (m_state)
          0: if (fk >= 0) begin
               m_cand = fk; m_cnt = 1; m_state = 1;
               if (m_cnt == DEB) begin m_push = 1'b1; m_state = 2; m_rel = 0; end
             end
          1: if (fk < 0) m_state = 0;
             else if (fk != m_cand) begin m_cand = fk; m_cnt = 1; end
             else begin
               m_cnt++;
               if (m_cnt == DEB) begin m_push = 1'b1; m_state = 2; m_rel = 0; end
             end
          default: if (fk >= 0) m_rel = 0;
                   else begin m_rel++; if (m_rel == DEB) m_state = 0; end
        endcase
      end
      if (m_pop && m_q.size() > 0) void'(m_q.pop_front());
      if (m_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(4'(m_cand));
        else m_ovf = 1'b1;
      end
    end
    @(negedge clk);
    if (chk_en) begin
      e_row  = ~(4'b0001 << ((m_edges / ST) % 4));
      e_data = {m_q.size() != 0, m_ovf, 2'b00, (m_q.size() != 0) ? m_q[0] : 4'h0};
      check("row_n", 32'(row_n), 32'(e_row));
      check("key_data", 32'(bus.key_data), 32'(e_data));
      check("key_valid", 32'(bus.key_valid), 32'(m_q.size() != 0));
      check("overflow", 32'(bus.overflow), 32'(m_ovf));
      check("fifo_count", 32'(bus.fifo_count), 32'(m_q.size()));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frames(input int n);
    cyc(FRAME * n);
  endtask

  task automatic align();
    while (m_edges % FRAME != 0) @(negedge clk);
  endtask

  task automatic set_keys(input logic [15:0] k, input int nf);
    align();
    keys = k;
    frames(nf);
  endtask

  task automatic ack_pulse();
    bus.key_ack = 1'b1;
    cyc(1);
    bus.key_ack = 1'b0;
    cyc(1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    cyc(3);
    check("rst_row_n", 32'(row_n), 32'h0000_000E);
    check("rst_key_data", 32'(bus.key_data), 32'h0000_0000);
    check("rst_fifo_count", 32'(bus.fifo_count), 32'h0000_0000);
    check("rst_overflow", 32'(bus.overflow), 32'h0000_0000);
    reset = 1'b1;
  endtask

  logic [3:0] rot [4];
  logic [15:0] rk;
  int sel;

  initial begin
    bus.key_ack = 1'b0;
    rot[0] = 4'b1101; rot[1] = 4'b1011; rot[2] = 4'b0111; rot[3] = 4'b1110;
    @(negedge clk);
    do_reset();

    // Row rotation after reset release
    for (int n = 1; n <= 16; n++) begin
      cyc(1);
      if (n == 3) check("rot_hold", 32'(row_n), 32'h0000_000E);
      if (n % 4 == 0) check("rot", 32'(row_n), 32'(rot[n/4-1]));
    end

    // Single press of key 9
    set_keys(16'h0200, 1);
    check("single_f1_count", 32'(bus.fifo_count), 32'd0);
    frames(1);
    check("single_data", 32'(bus.key_data), 32'h0000_0089);
    check("single_count", 32'(bus.fifo_count), 32'd1);
    frames(3);
    set_keys(16'h0000, 3);
    check("single_nopush", 32'(bus.fifo_count), 32'd1);
    ack_pulse();
    check("single_pop", 32'(bus.key_data), 32'h0000_0000);

    // Bounce on key 5
    set_keys(16'h0020, 1);
    set_keys(16'h0000, 1);
    set_keys(16'h0020, 1);
    check("bounce_f3", 32'(bus.fifo_count), 32'd0);
    frames(1);
    check("bounce_data", 32'(bus.key_data), 32'h0000_0085);
    set_keys(16'h0000, 2);
    ack_pulse();

    // Multi-key then change while held
    set_keys(16'h1008, 2);
    check("multi_data", 32'(bus.key_data), 32'h0000_0083);
    set_keys(16'h1000, 3);
    check("held_change", 32'(bus.fifo_count), 32'd1);
    set_keys(16'h0000, 2);
    set_keys(16'h1000, 2);
    check("redebounce_count", 32'(bus.fifo_count), 32'd2);
    set_keys(16'h0000, 2);
    ack_pulse();
    check("multi_head2", 32'(bus.key_data), 32'h0000_008C);
    ack_pulse();
    check("multi_empty", 32'(bus.fifo_count), 32'd0);

    // Overflow with keys 1..4 queued, then 7 dropped
    for (int k = 1; k <= 4; k++) begin
      set_keys(16'(1 << k), 2);
      set_keys(16'h0000, 2);
    end
    set_keys(16'h0080, 2);
    check("ovf_count", 32'(bus.fifo_count), 32'd4);
    check("ovf_flag", 32'(bus.overflow), 32'd1);
    check("ovf_data", 32'(bus.key_data), 32'h0000_00C1);
    set_keys(16'h0000, 2);
    for (int i = 0; i < 4; i++) begin
      check("ovf_head", 32'(bus.key_data), 32'(8'hC0 | 8'(i + 1)));
      ack_pulse();
    end
    check("ovf_drained", 32'(bus.fifo_count), 32'd0);
    check("ovf_sticky", 32'(bus.key_data), 32'h0000_0040);

    // Held ack pops once
    set_keys(16'h0400, 2);
    set_keys(16'h0000, 2);
    set_keys(16'h0800, 2);
    set_keys(16'h0000, 2);
    check("ackhold_pre", 32'(bus.fifo_count), 32'd2);
    bus.key_ack = 1'b1;
    cyc(10);
    check("ackhold_count", 32'(bus.fifo_count), 32'd1);
    check("ackhold_data", 32'(bus.key_data), 32'h0000_00CB);
    bus.key_ack = 1'b0;
    cyc(1);

    // Reset while a candidate is being debounced
    set_keys(16'h0040, 1);
    cyc(5);
    do_reset();
    frames(1);
    check("rst_cand_f1", 32'(bus.fifo_count), 32'd0);
    frames(1);
    check("rst_cand_data", 32'(bus.key_data), 32'h0000_0086);
    set_keys(16'h0000, 2);

    // Randomized keys per frame with random ack activity
    do_reset();
    rk = 16'h0000;
    for (int f = 0; f < 80; f++) begin
      align();
      sel = $urandom_range(0, 9);
      if (sel >= 4 && sel <= 6) rk = 16'h0000;
      else if (sel >= 7 && sel <= 8) rk = 16'(1 << $urandom_range(0, 15));
      else if (sel == 9) rk = 16'(1 << $urandom_range(0, 15)) | 16'(1 << $urandom_range(0, 15));
      keys = rk;
      for (int c = 0; c < FRAME; c++) begin
        bus.key_ack = ($urandom_range(0, 5) == 0);
        cyc(1);
      end
    end
    bus.key_ack = 1'b0;
    cyc(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Matrix-scanning input block for a 4x4 hex keypad. It is the input-side counterpart of the multiplexed 7-segment display driver.
- Drives one keypad row low at a time and senses the four columns. It debounces whole scan frames and queues debounced key codes in a small FIFO.
- Presents the queue head to one rv32e_soc 8-bit input port (i0). The SoC consumes an entry by toggling one of its output-port bits (ack).

Parameters:
- SCAN_TICKS, 120000: clock cycles each row is driven (5 ms at 24 MHz).
- DEBOUNCE_FRAMES, 4: consecutive identical frames needed to accept a press; also the number of consecutive empty frames needed to accept a release.
- FIFO_DEPTH, 4: key-code queue entries (power of two, 2..16).

Ports:
- clk, input, 1: system clock (24 MHz).
- reset, input, 1: synchronous, active-low reset.
- row_n, output, 4: active-low row drive, exactly one bit low at any time.
- col_n, input, 4: active-low column sense, externally pulled up, asynchronous.
- key_ack, input, 1: pop request; each rising edge pops one entry. Driven by a SoC output-port bit.
- key_data, output, 8: {key_valid, overflow, 2'b00, head_code[3:0]}; connects to SoC i0.
- key_valid, output, 1: FIFO not empty.
- overflow, output, 1: sticky flag, set when a key was dropped.
- fifo_count, output, clog2(FIFO_DEPTH)+1: number of queued entries.

Behaviour:
- Reset is synchronous and active-low. While reset==0 at a clk edge:
  - row index r=0, so row_n=4'b1110; scan timer=0.
  - Column synchronizer flops = 4'b1111.
  - FSM=IDLE; debounce and release counters=0.
  - FIFO empty: key_valid=0, fifo_count=0, overflow=0, key_data=8'h00.
  - Ack edge register=0.
  - Reset mid-scan or mid-debounce discards all partial state, including queued keys.
- Column input: col_n passes through a 2-flop synchronizer. The FSM uses only the synchronized value.
- Scan timing:
  - The timer counts 0..SCAN_TICKS-1.
  - At timer==SCAN_TICKS-1, the synchronized columns are sampled for row r. Then r advances and row_n updates the next cycle.
  - r wraps 3->0. One frame = 4*SCAN_TICKS cycles.
- Frame result:
  - Key code = 4*r + c, where c is the lowest column with col asserted (low).
  - frame_hit=1 if any key was seen in the frame. frame_key = lowest code seen.
  - Multiple keys pressed: only the lowest code counts; this is not an error.
  - The result is evaluated once per frame, at the row-3 sample.
- Debounce FSM, evaluated once per frame end:
  - IDLE: on hit, cand=frame_key, cnt=1, go to CAND.
  - CAND:
    - Hit with frame_key==cand: cnt+1. When cnt reaches DEBOUNCE_FRAMES, push cand and go to HELD.
    - Hit with a different key: cand=frame_key, cnt=1, stay in CAND.
    - No hit: go to IDLE.
    - With DEBOUNCE_FRAMES=1, IDLE pushes directly and goes to HELD.
  - HELD:
    - No hit: rel+1. When rel reaches DEBOUNCE_FRAMES, go to IDLE.
    - Any hit: rel=0. Changing key while held is not reported until the release is accepted.
- Latency: the push happens on the frame-end cycle. key_valid and key_data reflect the new entry on the next cycle.
- Ack handling:
  - pop = key_ack & ~key_ack_q, where key_ack_q is a registered copy.
  - key_ack is not synchronized; it is assumed synchronous to clk.
  - Holding key_ack high pops only once.
- FIFO rules:
  - Pop when empty: ignored.
  - Push when full without a simultaneous pop: entry dropped, overflow set. overflow clears only on reset.
  - Push and pop in the same cycle when full: both happen, count unchanged, no overflow.
  - Push and pop in the same cycle when empty: push happens, pop ignored, count becomes 1.
  - Pointers wrap modulo FIFO_DEPTH.
- key_data[3:0] = head entry when non-empty, else 4'h0. key_data[7] equals key_valid; key_data[6] equals overflow.

Test Plan (SCAN_TICKS=4, DEBOUNCE_FRAMES=2, FIFO_DEPTH=4, 16-cycle frame; keypad model shorts row to column):
- Reset check: hold reset low 3 cycles -> row_n=4'b1110, key_data=8'h00, fifo_count=0. After release, row_n rotates 1110->1101->1011->0111->1110, changing every 4 cycles.
- Single press: hold key 9 (row2,col1) for 5 frames, then release -> exactly one push at the end of frame 2. key_data=8'h89, fifo_count=1. No further push while held or after release.
- Bounce: key 5 present in frame 1, absent in frame 2, present in frames 3-4 -> no push after frame 1; push at end of frame 4; key_data=8'h85.
- Multi-key and held-change: keys 3 and 12 held together -> code 3 queued. Swapping to key 12 while held -> no new push until 2 empty frames, then 12 is pushed on re-debounce.
- FIFO overflow: queue keys 1,2,3,4 without ack, then press 7 -> fifo_count=4, overflow=1, key_data=8'hC1. Then toggle key_ack 4 times -> heads 1,2,3,4 in order. Finally fifo_count=0, key_data=8'h40.
- Ack edge and reset: hold key_ack high 10 cycles with 2 entries -> exactly one pop. Assert reset mid-CAND -> all outputs return to reset values, and a key still held is re-debounced from scratch.
